// File: rtl/nabp_shift_sequencer_pkg.sv
// nabp_shift_sequencer_pkg: shared frame/accumulator config, sequencer states and the per-angle step table.
package nabp_shift_sequencer_pkg;
    localparam int NABP_ANGLE_LEN = 180;
    localparam int NABP_ANGLE_W   = 8;
    localparam int NABP_ACCU_W    = 16;
    localparam int NABP_ACCU_FRAC = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_LINE,
        ST_FILL,
        ST_FILL_WAIT,
        ST_SHIFT,
        ST_SHIFT_WAIT,
        ST_ADVANCE
    } seq_state_e;

    // |tan| of the angle folded into [0,45] deg via a Pade approximant in Q16, rescaled to frac bits
    function automatic longint accu_step(input int idx, input int len, input int frac);
        longint m;
        longint x;
        longint x2;
        m  = (longint'(idx) * 180000 / len) % 90000;
        m  = (m > 45000) ? 90000 - m : m;
        x  = m * 205887 / 180000;
        x2 = x * x;
        return (x * ((longint'(15) <<< 32) - x2) / ((longint'(15) <<< 32) - 6 * x2)) >>> (16 - frac);
    endfunction
endpackage

// File: rtl/nabp_shift_sequencer_if.sv
// nabp_shift_sequencer_if: frame control, filtered-line gate and shifter fill/shift handshake.
interface nabp_shift_sequencer_if
    import nabp_shift_sequencer_pkg::*;
#(
    parameter int ANGLE_W = NABP_ANGLE_W,
    parameter int ACCU_W  = NABP_ACCU_W
) ();
    logic               frame_kick;
    logic               frame_done;
    logic               busy;
    logic               fr_line_ready;
    logic [ANGLE_W-1:0] fr_angle;
    logic               sh_fill_kick;
    logic               sh_shift_kick;
    logic [ACCU_W-1:0]  sh_accu_base;
    logic               sh_fill_done;
    logic               sh_shift_done;
    logic               proto_err;

    modport master (
        input  frame_kick, fr_line_ready, sh_fill_done, sh_shift_done,
        output frame_done, busy, fr_angle, sh_fill_kick, sh_shift_kick, sh_accu_base, proto_err
    );

    modport slave (
        output frame_kick, fr_line_ready, sh_fill_done, sh_shift_done,
        input  frame_done, busy, fr_angle, sh_fill_kick, sh_shift_kick, sh_accu_base, proto_err
    );
endinterface

// File: rtl/nabp_angle_step_rom.sv
// nabp_angle_step_rom: synchronous per-angle accumulator-step ROM, one-cycle read latency.
module nabp_angle_step_rom
    import nabp_shift_sequencer_pkg::*;
#(
    parameter int                          ANGLE_LEN = NABP_ANGLE_LEN,
    parameter int                          ANGLE_W   = NABP_ANGLE_W,
    parameter int                          ACCU_W    = NABP_ACCU_W,
    parameter int                          ACCU_FRAC = NABP_ACCU_FRAC,
    parameter bit                          USE_TABLE = 1'b1,
    parameter logic [ANGLE_LEN*ACCU_W-1:0] ROM_INIT  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rd_en,
    input  logic [ANGLE_W-1:0] addr,
    output logic [ACCU_W-1:0]  data
);
    logic [ACCU_W-1:0] rom [2**ANGLE_W];
    logic [ACCU_W-1:0] data_q;
    logic [ACCU_W-1:0] data_d;

    // Entries past ANGLE_LEN are unreachable; pad to the full address space
    for (genvar g = 0; g < 2**ANGLE_W; g++) begin : g_rom
        if (g >= ANGLE_LEN) begin : g_pad
            assign rom[g] = '0;
        end else if (USE_TABLE) begin : g_tab
            assign rom[g] = ACCU_W'(accu_step(g, ANGLE_LEN, ACCU_FRAC));
        end else begin : g_init
            assign rom[g] = ROM_INIT[g*ACCU_W +: ACCU_W];
        end
    end

    always_comb data_d = rd_en ? rom[addr] : data_q;

    always_ff @(posedge clk) data_q <= reset_n ? data_d : '0;

    assign data = data_q;
endmodule

// File: rtl/nabp_shift_sequencer.sv
// nabp_shift_sequencer: walks every projection angle, issuing fill then shift kicks to the shifter
// and waiting for each done pulse; flags done pulses that arrive outside their wait state.
module nabp_shift_sequencer
    import nabp_shift_sequencer_pkg::*;
#(
    parameter int                          ANGLE_LEN = NABP_ANGLE_LEN,
    parameter int                          ANGLE_W   = NABP_ANGLE_W,
    parameter int                          ACCU_W    = NABP_ACCU_W,
    parameter int                          ACCU_FRAC = NABP_ACCU_FRAC,
    parameter bit                          USE_TABLE = 1'b1,
    parameter logic [ANGLE_LEN*ACCU_W-1:0] ROM_INIT  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nabp_shift_sequencer_if.master bus
);
    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [ANGLE_W-1:0] angle_q;
    logic [ANGLE_W-1:0] angle_d;
    logic               proto_err_q;
    logic               proto_err_d;
    logic               last;

    assign last = angle_q == ANGLE_W'(ANGLE_LEN - 1);

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        proto_err_d = proto_err_q
                    | (bus.sh_fill_done  & (state_q != ST_FILL_WAIT))
                    | (bus.sh_shift_done & (state_q != ST_SHIFT_WAIT));
        case (state_q)
            ST_IDLE: begin
                state_d = bus.frame_kick ? ST_LOOKUP : ST_IDLE;
                angle_d = '0;
            end
            ST_LOOKUP:     state_d = ST_WAIT_LINE;
            ST_WAIT_LINE:  state_d = bus.fr_line_ready ? ST_FILL : ST_WAIT_LINE;
            ST_FILL:       state_d = ST_FILL_WAIT;
            ST_FILL_WAIT:  state_d = bus.sh_fill_done ? ST_SHIFT : ST_FILL_WAIT;
            ST_SHIFT:      state_d = ST_SHIFT_WAIT;
            ST_SHIFT_WAIT: state_d = bus.sh_shift_done ? ST_ADVANCE : ST_SHIFT_WAIT;
            ST_ADVANCE: begin
                state_d = last ? ST_IDLE : ST_LOOKUP;
                angle_d = last ? '0 : angle_q + 1'b1;
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            angle_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Step is only reloaded in LOOKUP, so it holds from the fill kick through shift_done
    nabp_angle_step_rom #(
        .ANGLE_LEN (ANGLE_LEN),
        .ANGLE_W   (ANGLE_W),
        .ACCU_W    (ACCU_W),
        .ACCU_FRAC (ACCU_FRAC),
        .USE_TABLE (USE_TABLE),
        .ROM_INIT  (ROM_INIT)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (state_q == ST_LOOKUP),
        .addr    (angle_q),
        .data    (bus.sh_accu_base)
    );

    assign bus.frame_done    = (state_q == ST_ADVANCE) && last;
    assign bus.busy          = state_q != ST_IDLE;
    assign bus.fr_angle      = angle_q;
    assign bus.sh_fill_kick  = state_q == ST_FILL;
    assign bus.sh_shift_kick = state_q == ST_SHIFT;
    assign bus.proto_err     = proto_err_q;
endmodule

// File: tb/tb_nabp_shift_sequencer.sv
// tb_nabp_shift_sequencer: directed scenarios on a 4-angle and a 1-angle sequencer with a shifter responder.
module tb_nabp_shift_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nabp_shift_sequencer_if #(.ANGLE_W(8), .ACCU_W(16)) b4 ();
    nabp_shift_sequencer_if #(.ANGLE_W(8), .ACCU_W(16)) b1 ();

    nabp_shift_sequencer #(
        .ANGLE_LEN(4), .ANGLE_W(8), .ACCU_W(16), .ACCU_FRAC(8),
        .USE_TABLE(1'b0), .ROM_INIT(64'h00C0_0040_0080_0100)
    ) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    nabp_shift_sequencer #(
        .ANGLE_LEN(1), .ANGLE_W(8), .ACCU_W(16), .ACCU_FRAC(8),
        .USE_TABLE(1'b0), .ROM_INIT(16'h0123)
    ) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] rom4 [4];

    logic model_en, m_fd, m_sd, inj_fd, inj_sd;
    int   m_fcnt, m_scnt;
    assign b4.sh_fill_done  = m_fd | inj_fd;
    assign b4.sh_shift_done = m_sd | inj_sd;

    int          fill_n, shift_n, done_n, stab_bad, kick_cyc, done_cyc;
    int          fill_cyc [8];
    int          shift_cyc [8];
    logic [15:0] fill_acc [8];
    logic [15:0] shift_acc [8];
    logic [7:0]  fill_ang [8];
    logic        hold, have_shift;
    logic [15:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    // Shifter model: fill_done 5 cycles and shift_done 10 cycles after the respective kick
    initial begin
        m_fd = 1'b0; m_sd = 1'b0; m_fcnt = 0; m_scnt = 0;
        forever begin
            @(posedge clk); #1;
            m_fd = 1'b0; m_sd = 1'b0;
            if (!model_en || !reset_n) begin
                m_fcnt = 0; m_scnt = 0;
            end else begin
                if (m_fcnt > 0) begin m_fcnt--; m_fd = (m_fcnt == 0); end
                if (m_scnt > 0) begin m_scnt--; m_sd = (m_scnt == 0); end
                if (b4.sh_fill_kick) m_fcnt = 5;
                if (b4.sh_shift_kick) m_scnt = 10;
            end
        end
    end

    // Recorder for kicks, step values and frame_done on the 4-angle instance
    initial begin
        hold = 1'b0; have_shift = 1'b0; hold_val = '0;
        fill_n = 0; shift_n = 0; done_n = 0; stab_bad = 0;
        forever begin
            @(negedge clk);
            if (b4.sh_fill_kick) begin
                if (fill_n < 8) begin
                    fill_cyc[fill_n] = cyc; fill_acc[fill_n] = b4.sh_accu_base; fill_ang[fill_n] = b4.fr_angle;
                end
                fill_n++;
                hold = 1'b1; have_shift = 1'b0; hold_val = b4.sh_accu_base;
            end else if (hold && b4.sh_accu_base !== hold_val) stab_bad++;
            if (b4.sh_shift_kick) begin
                if (shift_n < 8) begin shift_cyc[shift_n] = cyc; shift_acc[shift_n] = b4.sh_accu_base; end
                shift_n++;
                have_shift = 1'b1;
            end
            if (hold && have_shift && b4.sh_shift_done) hold = 1'b0;
            if (b4.frame_done) begin done_n++; done_cyc = cyc; end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        fill_n = 0; shift_n = 0; done_n = 0; stab_bad = 0; hold = 1'b0;
    endtask

    task automatic kick4();
        b4.frame_kick = 1'b1; kick_cyc = cyc;
        tick();
        b4.frame_kick = 1'b0;
    endtask

    task automatic wait_fill(input int n, input int max, output bit ok);
        for (int i = 0; i < max && fill_n < n; i++) tick();
        ok = fill_n >= n;
    endtask

    task automatic wait_shift(input int n, input int max, output bit ok);
        for (int i = 0; i < max && shift_n < n; i++) tick();
        ok = shift_n >= n;
    endtask

    task automatic wait_done(input int n, input int max, output bit ok);
        for (int i = 0; i < max && done_n < n; i++) tick();
        ok = done_n >= n;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({b4.busy, b4.sh_fill_kick, b4.sh_shift_kick, b4.frame_done, b4.proto_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/fill/shift/done/err=%b expected 00000",
                     {b4.busy, b4.sh_fill_kick, b4.sh_shift_kick, b4.frame_done, b4.proto_err});
        end
        checks++;
        if (b4.fr_angle !== 8'd0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", b4.fr_angle); end
        checks++;
        if (b4.sh_accu_base !== 16'h0) begin errors++; $display("FAIL reset_accu: got %h expected 0000", b4.sh_accu_base); end
        checks++;
        if ({b1.busy, b1.proto_err} !== 2'b00) begin errors++; $display("FAIL reset_single: busy/err=%b expected 00", {b1.busy, b1.proto_err}); end
    endtask

    task automatic test_frame();
        bit ok;
        clear_mon();
        model_en = 1'b1;
        b4.fr_line_ready = 1'b1;
        kick4();
        checks++;
        if (b4.busy !== 1'b1) begin errors++; $display("FAIL frame_busy_start: got %b expected 1", b4.busy); end
        wait_done(1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_done_timeout: done count %0d expected 1", done_n); end
        checks++;
        if (b4.frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse: got %b expected 1", b4.frame_done); end
        tick();
        checks++;
        if ({b4.busy, b4.frame_done} !== 2'b00) begin errors++; $display("FAIL frame_after: busy/done=%b expected 00", {b4.busy, b4.frame_done}); end
        checks++;
        if (fill_n != 4 || shift_n != 4) begin errors++; $display("FAIL frame_kicks: fill %0d shift %0d expected 4 4", fill_n, shift_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fill_acc[i] !== rom4[i] || shift_acc[i] !== rom4[i]) begin
                errors++;
                $display("FAIL frame_accu[%0d]: fill %h shift %h expected %h", i, fill_acc[i], shift_acc[i], rom4[i]);
            end
            checks++;
            if (fill_ang[i] !== 8'(i)) begin errors++; $display("FAIL frame_angle[%0d]: got %0d expected %0d", i, fill_ang[i], i); end
        end
        checks++;
        if (fill_cyc[0] != kick_cyc + 3) begin errors++; $display("FAIL frame_first_fill: cycle %0d expected %0d", fill_cyc[0], kick_cyc + 3); end
        checks++;
        if (shift_cyc[0] - fill_cyc[0] != 6) begin errors++; $display("FAIL frame_fill_to_shift: %0d cycles expected 6", shift_cyc[0] - fill_cyc[0]); end
        checks++;
        if (fill_cyc[1] - fill_cyc[0] != 20) begin errors++; $display("FAIL frame_angle_period: %0d cycles expected 20", fill_cyc[1] - fill_cyc[0]); end
        checks++;
        if (done_cyc != shift_cyc[3] + 11) begin errors++; $display("FAIL frame_done_cycle: %0d expected %0d", done_cyc, shift_cyc[3] + 11); end
        checks++;
        if (stab_bad != 0 || b4.proto_err !== 1'b0) begin errors++; $display("FAIL frame_clean: unstable %0d err %b expected 0 0", stab_bad, b4.proto_err); end
    endtask

    task automatic test_line_hold();
        bit ok;
        int r;
        repeat (3) tick();
        clear_mon();
        b4.fr_line_ready = 1'b1;
        kick4();
        wait_shift(2, 100, ok);
        b4.fr_line_ready = 1'b0;
        for (int i = 0; i < 50 && b4.fr_angle !== 8'd2; i++) tick();
        checks++;
        if (b4.fr_angle !== 8'd2) begin errors++; $display("FAIL hold_reach: angle %0d expected 2", b4.fr_angle); end
        repeat (20) tick();
        checks++;
        if (fill_n != 2 || b4.sh_fill_kick !== 1'b0) begin errors++; $display("FAIL hold_no_fill: fills %0d kick %b expected 2 0", fill_n, b4.sh_fill_kick); end
        checks++;
        if (b4.fr_angle !== 8'd2) begin errors++; $display("FAIL hold_angle: got %0d expected 2", b4.fr_angle); end
        b4.fr_line_ready = 1'b1;
        r = cyc;
        wait_fill(3, 5, ok);
        checks++;
        if (!ok || fill_cyc[2] != r + 1) begin errors++; $display("FAIL hold_release: fill cycle %0d expected %0d", fill_cyc[2], r + 1); end
        checks++;
        if (fill_ang[2] !== 8'd2 || fill_acc[2] !== 16'h0040) begin
            errors++; $display("FAIL hold_fill_data: angle %0d accu %h expected 2 0040", fill_ang[2], fill_acc[2]);
        end
        wait_done(1, 200, ok);
        checks++;
        if (!ok || fill_n != 4) begin errors++; $display("FAIL hold_finish: done %0d fills %0d expected 1 4", done_n, fill_n); end
    endtask

    task automatic test_proto_err();
        bit ok;
        repeat (3) tick();
        clear_mon();
        kick4();
        wait_fill(2, 100, ok);
        tick();
        inj_sd = 1'b1;
        tick();
        inj_sd = 1'b0;
        checks++;
        if (b4.proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b expected 1", b4.proto_err); end
        checks++;
        if (shift_n != 1 || b4.fr_angle !== 8'd1) begin errors++; $display("FAIL proto_ignored: shifts %0d angle %0d expected 1 1", shift_n, b4.fr_angle); end
        wait_done(1, 200, ok);
        checks++;
        if (!ok || fill_n != 4 || shift_n != 4) begin errors++; $display("FAIL proto_continue: done %0d fills %0d shifts %0d expected 1 4 4", done_n, fill_n, shift_n); end
        repeat (10) tick();
        checks++;
        if (b4.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", b4.proto_err); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        clear_mon();
        kick4();
        wait_shift(4, 200, ok);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({b4.busy, b4.sh_fill_kick, b4.sh_shift_kick, b4.frame_done, b4.proto_err} !== 5'b0) begin
            errors++;
            $display("FAIL abort_flags: busy/fill/shift/done/err=%b expected 00000",
                     {b4.busy, b4.sh_fill_kick, b4.sh_shift_kick, b4.frame_done, b4.proto_err});
        end
        checks++;
        if (b4.fr_angle !== 8'd0 || b4.sh_accu_base !== 16'h0) begin errors++; $display("FAIL abort_angle: angle %0d accu %h expected 0 0000", b4.fr_angle, b4.sh_accu_base); end
        repeat (15) tick();
        checks++;
        if (fill_n != 4 || done_n != 0 || b4.proto_err !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: fills %0d done %0d err %b expected 4 0 0", fill_n, done_n, b4.proto_err);
        end
        clear_mon();
        kick4();
        wait_done(1, 200, ok);
        checks++;
        if (!ok || fill_n != 4 || fill_ang[0] !== 8'd0 || fill_acc[0] !== 16'h0100) begin
            errors++; $display("FAIL abort_restart: done %0d fills %0d angle0 %0d accu0 %h expected 1 4 0 0100", done_n, fill_n, fill_ang[0], fill_acc[0]);
        end
    endtask

    task automatic test_ignore_kick();
        bit ok;
        repeat (3) tick();
        clear_mon();
        kick4();
        wait_fill(1, 20, ok);
        b4.frame_kick = 1'b1; tick(); b4.frame_kick = 1'b0;
        wait_fill(3, 100, ok);
        b4.frame_kick = 1'b1; tick(); b4.frame_kick = 1'b0;
        wait_done(1, 200, ok);
        checks++;
        if (!ok || fill_ang[1] !== 8'd1 || fill_ang[3] !== 8'd3) begin
            errors++; $display("FAIL kick_ignored: done %0d angle1 %0d angle3 %0d expected 1 1 3", done_n, fill_ang[1], fill_ang[3]);
        end
        repeat (60) tick();
        checks++;
        if (done_n != 1 || fill_n != 4 || b4.busy !== 1'b0) begin
            errors++; $display("FAIL kick_single_done: done %0d fills %0d busy %b expected 1 4 0", done_n, fill_n, b4.busy);
        end
    endtask

    task automatic test_single_angle();
        b1.fr_line_ready = 1'b1;
        b1.frame_kick = 1'b1; tick(); b1.frame_kick = 1'b0;
        for (int i = 0; i < 10 && b1.sh_fill_kick !== 1'b1; i++) tick();
        checks++;
        if (b1.sh_fill_kick !== 1'b1 || b1.sh_accu_base !== 16'h0123 || b1.fr_angle !== 8'd0) begin
            errors++; $display("FAIL single_fill: kick %b accu %h angle %0d expected 1 0123 0", b1.sh_fill_kick, b1.sh_accu_base, b1.fr_angle);
        end
        repeat (4) tick();
        b1.sh_fill_done = 1'b1; tick(); b1.sh_fill_done = 1'b0;
        for (int i = 0; i < 10 && b1.sh_shift_kick !== 1'b1; i++) tick();
        checks++;
        if (b1.sh_shift_kick !== 1'b1 || b1.sh_accu_base !== 16'h0123) begin
            errors++; $display("FAIL single_shift: kick %b accu %h expected 1 0123", b1.sh_shift_kick, b1.sh_accu_base);
        end
        repeat (3) tick();
        b1.sh_shift_done = 1'b1; tick(); b1.sh_shift_done = 1'b0;
        checks++;
        if (b1.frame_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", b1.frame_done); end
        tick();
        checks++;
        if ({b1.frame_done, b1.busy, b1.proto_err} !== 3'b000) begin
            errors++; $display("FAIL single_after: done/busy/err=%b expected 000", {b1.frame_done, b1.busy, b1.proto_err});
        end
    endtask

    initial begin
        rom4 = '{16'h0100, 16'h0080, 16'h0040, 16'h00C0};
        reset_n = 1'b0;
        model_en = 1'b0; inj_fd = 1'b0; inj_sd = 1'b0;
        b4.frame_kick = 1'b0; b4.fr_line_ready = 1'b0;
        b1.frame_kick = 1'b0; b1.fr_line_ready = 1'b0;
        b1.sh_fill_done = 1'b0; b1.sh_shift_done = 1'b0;
        test_reset();
        test_frame();
        test_line_hold();
        test_proto_err();
        test_reset_abort();
        test_ignore_kick();
        test_single_angle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
